// File: rtl/frame_sdram_pkg.sv
// ---------------------------------------------------------------------------
// frame_sdram_pkg
// Declarations shared by the SDRAM frame writer and the frame reader:
//   - frame_state_t : writer/reader sequencing state encoding
//   - FRAME_STRIDE_DEF, BURST_SIZE_DEF : default buffer geometry
//   - FRAME_BASE_MULT : frame-buffer index -> multiple of the stride
//   - frame_base()    : base word address of a frame buffer
// ---------------------------------------------------------------------------
package frame_sdram_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      WR_BURST  = 2'd2,
      DONE      = 2'd3
   } frame_state_t;

   localparam int unsigned FRAME_STRIDE_DEF = 32'd2073600;
   localparam int unsigned BURST_SIZE_DEF   = 32'd128;
   localparam int unsigned NUM_BUFFERS      = 3;

   // Buffers sit at 0, 1x and 2x the stride.
   localparam int unsigned FRAME_BASE_MULT [NUM_BUFFERS] = '{0, 1, 2};

   function automatic logic [31:0] frame_base(input logic [1:0] idx,
                                              input int unsigned stride);
      logic [31:0] base;
      base = '0;
      if (idx < 2'(NUM_BUFFERS))
         base = FRAME_BASE_MULT[idx] * stride;
      return base;
   endfunction

endpackage

// File: rtl/frame_write_sdram_lot_if.sv
// ---------------------------------------------------------------------------
// frame_write_sdram_lot_if
// Bundles the pixel-FIFO read side and the SDRAM controller burst-write port.
//   master : the frame writer (pops the FIFO, drives burst requests/data)
//   slave  : the environment (FIFO + controller)
// Signals:
//   fifo_rd_usedw     words available in the show-ahead FIFO
//   fifo_q            FIFO head word
//   fifo_rd_en        FIFO pop
//   wr_burst_req/len/addr  burst request, length, base word address
//   wr_burst_data_req controller consumes one word this cycle
//   wr_burst_data     write data
//   wr_burst_finish   controller burst-complete pulse
// ---------------------------------------------------------------------------
interface frame_write_sdram_lot_if #(
   parameter int MEM_DATA_BITS = 32,
   parameter int ADDR_BITS     = 23,
   parameter int BURST_BITS    = 10
);
   logic [11:0]              fifo_rd_usedw;
   logic [MEM_DATA_BITS-1:0] fifo_q;
   logic                     fifo_rd_en;
   logic                     wr_burst_req;
   logic [BURST_BITS-1:0]    wr_burst_len;
   logic [ADDR_BITS-1:0]     wr_burst_addr;
   logic                     wr_burst_data_req;
   logic [MEM_DATA_BITS-1:0] wr_burst_data;
   logic                     wr_burst_finish;

   modport master (
      input  fifo_rd_usedw, fifo_q, wr_burst_data_req, wr_burst_finish,
      output fifo_rd_en, wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data
   );

   modport slave (
      output fifo_rd_usedw, fifo_q, wr_burst_data_req, wr_burst_finish,
      input  fifo_rd_en, wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data
   );
endinterface

// File: rtl/frame_wr_addr_gen.sv
// ---------------------------------------------------------------------------
// frame_wr_addr_gen
// Tracks burst index within a frame, word offset within the frame and the
// frame-buffer index; produces the next burst address.
// Ports:
//   mem_clk, rst : clock, synchronous active-high reset
//   clear        : restart at frame 0, burst 0
//   advance      : a burst has completed
//   addr         : frame_base(frame index) + offset
//   frame_last   : current burst is the last of its frame
//   all_last     : current burst is the last of the last frame
// ---------------------------------------------------------------------------
module frame_wr_addr_gen
   import frame_sdram_pkg::*;
#(
   parameter int          ADDR_BITS    = 23,
   parameter int          BURST_SIZE   = 128,
   parameter int          FRAME_BURSTS = 2560,
   parameter int unsigned FRAME_STRIDE = FRAME_STRIDE_DEF,
   parameter int          NUM_FRAMES   = 3
) (
   input  logic                 mem_clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 advance,
   output logic [ADDR_BITS-1:0] addr,
   output logic                 frame_last,
   output logic                 all_last
);

   logic [11:0]          burst_cnt_q, burst_cnt_d;
   logic [ADDR_BITS-1:0] offset_q,    offset_d;
   logic [1:0]           frame_idx_q, frame_idx_d;

   assign frame_last = (burst_cnt_q == 12'(FRAME_BURSTS - 1));
   assign all_last   = frame_last && (frame_idx_q == 2'(NUM_FRAMES - 1));
   assign addr       = ADDR_BITS'(frame_base(frame_idx_q, FRAME_STRIDE)) + offset_q;

   always_comb begin
      burst_cnt_d = burst_cnt_q;
      offset_d    = offset_q;
      frame_idx_d = frame_idx_q;
      if (clear) begin
         burst_cnt_d = '0;
         offset_d    = '0;
         frame_idx_d = '0;
      end else if (advance) begin
         if (frame_last) begin
            burst_cnt_d = '0;
            offset_d    = '0;
            // Parked on the last buffer once all frames are written, so the
            // index never points past the base table.
            if (!all_last)
               frame_idx_d = frame_idx_q + 2'd1;
         end else begin
            burst_cnt_d = burst_cnt_q + 12'd1;
            offset_d    = offset_q + ADDR_BITS'(BURST_SIZE);
         end
      end
   end

   always_ff @(posedge mem_clk) begin
      if (rst) begin
         burst_cnt_q <= '0;
         offset_q    <= '0;
         frame_idx_q <= '0;
      end else begin
         burst_cnt_q <= burst_cnt_d;
         offset_q    <= offset_d;
         frame_idx_q <= frame_idx_d;
      end
   end

endmodule

// File: rtl/frame_write_sdram_lot.sv
// ---------------------------------------------------------------------------
// frame_write_sdram_lot
// Burst-write master: on write_start, fills NUM_FRAMES SDRAM frame buffers
// from the show-ahead pixel FIFO, FRAME_BURSTS bursts of BURST_SIZE words
// each, then holds write_allframe_done high for the frame reader.
// Ports:
//   mem_clk, rst        : sole clock, synchronous active-high reset
//   write_start         : one-cycle pulse, accepted in IDLE or DONE
//   bus (master)        : FIFO read side + controller burst-write port
//   frame_writecnt      : frames fully written since start (0..3)
//   write_allframe_done : level, set after the last burst of the last frame
//   beat_err            : only with FRAME_WR_BEAT_CHECK_EN defined; sticky,
//                         set when a burst finishes with a pop count other
//                         than BURST_SIZE, cleared by write_start
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for write_start
// WAIT_DATA | waiting for a full burst worth of words in the FIFO
// WR_BURST  | burst requested/in flight; pops follow wr_burst_data_req
// DONE      | all frames written, done held until the next write_start
// ---------------------------------------------------------------------------
module frame_write_sdram_lot
   import frame_sdram_pkg::*;
#(
   parameter int          MEM_DATA_BITS = 32,
   parameter int          ADDR_BITS     = 23,
   parameter int          BURST_BITS    = 10,
   parameter int          BURST_SIZE    = int'(BURST_SIZE_DEF),
   parameter int          FRAME_BURSTS  = 2560,
   parameter int unsigned FRAME_STRIDE  = FRAME_STRIDE_DEF,
   parameter int          NUM_FRAMES    = 3
) (
   input  logic                     mem_clk,
   input  logic                     rst,
   input  logic                     write_start,
   frame_write_sdram_lot_if.master  bus,
   output logic [1:0]               frame_writecnt,
   output logic                     write_allframe_done
`ifdef FRAME_WR_BEAT_CHECK_EN
   ,
   output logic                     beat_err
`endif
);

   frame_state_t          state_q, state_d;
   logic                  req_q,      req_d;
   logic [BURST_BITS-1:0] len_q,      len_d;
   logic [ADDR_BITS-1:0]  addr_q,     addr_d;
   logic [1:0]            writecnt_q, writecnt_d;
   logic                  done_q,     done_d;

   logic                  addr_clear;
   logic                  addr_adv;
   logic [ADDR_BITS-1:0]  next_addr;
   logic                  frame_last;
   logic                  all_last;
   logic                  fifo_rd_en;
   logic [MEM_DATA_BITS-1:0] head_word;

   frame_wr_addr_gen #(
      .ADDR_BITS    (ADDR_BITS),
      .BURST_SIZE   (BURST_SIZE),
      .FRAME_BURSTS (FRAME_BURSTS),
      .FRAME_STRIDE (FRAME_STRIDE),
      .NUM_FRAMES   (NUM_FRAMES)
   ) u_addr_gen (
      .mem_clk    (mem_clk),
      .rst        (rst),
      .clear      (addr_clear),
      .advance    (addr_adv),
      .addr       (next_addr),
      .frame_last (frame_last),
      .all_last   (all_last)
   );

   // Show-ahead FIFO: the head word is the write data, the controller's
   // data request is the pop, no pipeline in between.
   assign fifo_rd_en         = bus.wr_burst_data_req && (state_q == WR_BURST);
   assign head_word          = bus.fifo_q;
   assign bus.fifo_rd_en     = fifo_rd_en;
   assign bus.wr_burst_data  = head_word;
   assign bus.wr_burst_req   = req_q;
   assign bus.wr_burst_len   = len_q;
   assign bus.wr_burst_addr  = addr_q;
   assign frame_writecnt      = writecnt_q;
   assign write_allframe_done = done_q;

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      len_d      = len_q;
      addr_d     = addr_q;
      writecnt_d = writecnt_q;
      done_d     = done_q;
      addr_clear = 1'b0;
      addr_adv   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (write_start) begin
               state_d    = WAIT_DATA;
               writecnt_d = '0;
               done_d     = 1'b0;
               addr_clear = 1'b1;
            end
         end
         WAIT_DATA: begin
            if (bus.fifo_rd_usedw >= 12'(BURST_SIZE)) begin
               addr_d  = next_addr;
               req_d   = 1'b1;
               len_d   = BURST_BITS'(BURST_SIZE);
               state_d = WR_BURST;
            end
         end
         WR_BURST: begin
            // Controller has accepted the request once it starts pulling data.
            if (bus.wr_burst_data_req)
               req_d = 1'b0;
            if (bus.wr_burst_finish) begin
               addr_adv = 1'b1;
               if (frame_last)
                  writecnt_d = writecnt_q + 2'd1;
               if (all_last) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = WAIT_DATA;
               end
            end
         end
      endcase
   end

   always_ff @(posedge mem_clk) begin
      if (rst) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         len_q      <= BURST_BITS'(BURST_SIZE);
         addr_q     <= '0;
         writecnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         len_q      <= len_d;
         addr_q     <= addr_d;
         writecnt_q <= writecnt_d;
         done_q     <= done_d;
      end
   end

`ifdef FRAME_WR_BEAT_CHECK_EN
   logic [BURST_BITS:0] beat_cnt_q, beat_cnt_d;
   logic [BURST_BITS:0] beat_total;
   logic                beat_err_q, beat_err_d;
   logic                start_accept;

   assign start_accept = write_start && ((state_q == IDLE) || (state_q == DONE));
   assign beat_err     = beat_err_q;

   always_comb begin
      // A pop in the finish cycle still belongs to the burst being closed.
      beat_total = beat_cnt_q + {{BURST_BITS{1'b0}}, fifo_rd_en};
      beat_cnt_d = beat_cnt_q;
      beat_err_d = beat_err_q;
      if (start_accept) begin
         beat_cnt_d = '0;
         beat_err_d = 1'b0;
      end else if ((state_q == WR_BURST) && bus.wr_burst_finish) begin
         beat_cnt_d = '0;
         if (beat_total != (BURST_BITS+1)'(BURST_SIZE))
            beat_err_d = 1'b1;
      end else begin
         beat_cnt_d = beat_total;
      end
   end

   always_ff @(posedge mem_clk) begin
      if (rst) begin
         beat_cnt_q <= '0;
         beat_err_q <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         beat_err_q <= beat_err_d;
      end
   end
`endif

endmodule

// File: tb/tb_frame_write_sdram_lot.sv
module tb_frame_write_sdram_lot;
   import frame_sdram_pkg::*;

   localparam int          MDB = 32;
   localparam int          AB  = 23;
   localparam int          BB  = 10;
   localparam int          BS  = 8;
   localparam int          FB  = 4;
   localparam int          NF  = 3;
   localparam int unsigned FS  = FRAME_STRIDE_DEF;

   logic       mem_clk = 1'b0;
   logic       rst;
   logic       write_start;
   logic [1:0] frame_writecnt;
   logic       write_allframe_done;
`ifdef FRAME_WR_BEAT_CHECK_EN
   logic       beat_err;
`endif

   frame_write_sdram_lot_if #(.MEM_DATA_BITS(MDB), .ADDR_BITS(AB), .BURST_BITS(BB)) bus ();

   frame_write_sdram_lot #(
      .MEM_DATA_BITS (MDB),
      .ADDR_BITS     (AB),
      .BURST_BITS    (BB),
      .BURST_SIZE    (BS),
      .FRAME_BURSTS  (FB),
      .FRAME_STRIDE  (FS),
      .NUM_FRAMES    (NF)
   ) dut (
      .mem_clk             (mem_clk),
      .rst                 (rst),
      .write_start         (write_start),
      .bus                 (bus),
      .frame_writecnt      (frame_writecnt),
      .write_allframe_done (write_allframe_done)
`ifdef FRAME_WR_BEAT_CHECK_EN
      ,
      .beat_err            (beat_err)
`endif
   );

   always #5 mem_clk = ~mem_clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int bursts_done;
   logic [AB-1:0]  exp_addr_q [$];
   logic [MDB-1:0] exp_data_q [$];

   task automatic tick();
      @(posedge mem_clk);
      #1;
   endtask

   task automatic push_sequence();
      exp_addr_q.delete();
      for (int f = 0; f < NF; f++)
         for (int b = 0; b < FB; b++)
            exp_addr_q.push_back(AB'(f * FS + b * BS));
   endtask

   // Plays the controller for one burst: wait for the request, check it,
   // pull 'beats' words, then finish (optionally in the last beat's cycle).
   task automatic do_burst(input int beats, input bit overlap, input bit start_mid);
      int waited = 0;
      int pops = 0;
      logic [AB-1:0]  ea;
      logic [MDB-1:0] d;
      logic [MDB-1:0] ed;
      while (bus.wr_burst_req !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      total_cnt++;
      if (waited >= 50) begin
         $display("FAIL req_timeout: wr_burst_req not seen within 50 cycles (burst %0d)", bursts_done);
         return;
      end
      pass_cnt++;
      total_cnt++;
      if (exp_addr_q.size() == 0) begin
         $display("FAIL addr_seq: unexpected burst at addr %0d", bus.wr_burst_addr);
      end else begin
         ea = exp_addr_q.pop_front();
         if (bus.wr_burst_addr !== ea)
            $display("FAIL addr_seq: got %0d want %0d (burst %0d)", bus.wr_burst_addr, ea, bursts_done);
         else pass_cnt++;
      end
      total_cnt++;
      if (bus.wr_burst_len !== BB'(BS))
         $display("FAIL burst_len: got %0d want %0d", bus.wr_burst_len, BS);
      else pass_cnt++;
      for (int i = 0; i < beats; i++) begin
         d = $urandom;
         bus.fifo_q = d;
         exp_data_q.push_back(d);
         bus.wr_burst_data_req = 1'b1;
         bus.wr_burst_finish   = overlap && (i == beats - 1);
         if (start_mid && i == 1) write_start = 1'b1;
         #1;
         if (bus.fifo_rd_en === 1'b1) pops++;
         ed = exp_data_q.pop_front();
         total_cnt++;
         if (bus.wr_burst_data !== ed)
            $display("FAIL wr_data: got %h want %h", bus.wr_burst_data, ed);
         else pass_cnt++;
         @(posedge mem_clk);
         #1;
         write_start = 1'b0;
         if (i == 0) begin
            total_cnt++;
            if (bus.wr_burst_req !== 1'b0)
               $display("FAIL req_drop: got %b want 0 after first data_req", bus.wr_burst_req);
            else pass_cnt++;
         end
      end
      bus.wr_burst_data_req = 1'b0;
      if (!overlap) begin
         bus.wr_burst_finish = 1'b1;
         tick();
      end
      bus.wr_burst_finish = 1'b0;
      bursts_done++;
      total_cnt++;
      if (pops != beats)
         $display("FAIL pop_count: got %0d want %0d", pops, beats);
      else pass_cnt++;
      total_cnt++;
      if (frame_writecnt !== 2'(bursts_done / FB))
         $display("FAIL frame_writecnt: got %0d want %0d", frame_writecnt, bursts_done / FB);
      else pass_cnt++;
      total_cnt++;
      if (write_allframe_done !== (bursts_done == FB * NF))
         $display("FAIL done_flag: got %b want %b", write_allframe_done, bursts_done == FB * NF);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.wr_burst_data_req = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (bus.wr_burst_req !== 1'b0 || bus.wr_burst_len !== BB'(BS) || bus.wr_burst_addr !== '0)
         $display("FAIL reset_bus: req %b len %0d addr %0d want 0/%0d/0",
                  bus.wr_burst_req, bus.wr_burst_len, bus.wr_burst_addr, BS);
      else pass_cnt++;
      total_cnt++;
      if (frame_writecnt !== 2'd0 || write_allframe_done !== 1'b0)
         $display("FAIL reset_status: cnt %0d done %b want 0/0", frame_writecnt, write_allframe_done);
      else pass_cnt++;
      rst = 1'b0;
      tick();
      total_cnt++;
      if (bus.fifo_rd_en !== 1'b0)
         $display("FAIL idle_pop: fifo_rd_en %b want 0 in IDLE", bus.fifo_rd_en);
      else pass_cnt++;
      bus.wr_burst_data_req = 1'b0;
`ifdef FRAME_WR_BEAT_CHECK_EN
      total_cnt++;
      if (beat_err !== 1'b0)
         $display("FAIL reset_beat_err: got %b want 0", beat_err);
      else pass_cnt++;
`endif
   endtask

   task automatic test_threshold();
      int high = 0;
      push_sequence();
      bursts_done = 0;
      bus.fifo_rd_usedw = 12'd7;
      write_start = 1'b1;
      tick();
      write_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.wr_burst_req !== 1'b0) high++;
      end
      total_cnt++;
      if (high != 0)
         $display("FAIL below_threshold: req high %0d cycles want 0", high);
      else pass_cnt++;
      bus.fifo_rd_usedw = 12'd8;
      tick();
      total_cnt++;
      if (bus.wr_burst_req !== 1'b1)
         $display("FAIL at_threshold: req %b want 1 one cycle after usedw=8", bus.wr_burst_req);
      else pass_cnt++;
      bus.fifo_rd_usedw = 12'd16;
   endtask

   task automatic test_frames();
      for (int k = 0; k < FB * NF; k++)
         do_burst(BS, (k % 3) == 1, k == 5);
      total_cnt++;
      if (exp_addr_q.size() != 0)
         $display("FAIL addr_left: %0d expected bursts not seen", exp_addr_q.size());
      else pass_cnt++;
`ifdef FRAME_WR_BEAT_CHECK_EN
      total_cnt++;
      if (beat_err !== 1'b0)
         $display("FAIL beat_err_clean: got %b want 0", beat_err);
      else pass_cnt++;
`endif
   endtask

   task automatic test_done_hold();
      int drops = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (write_allframe_done !== 1'b1 || bus.wr_burst_req !== 1'b0) drops++;
      end
      total_cnt++;
      if (drops != 0)
         $display("FAIL done_hold: %0d bad cycles of 100 want 0", drops);
      else pass_cnt++;
   endtask

   task automatic test_restart();
      write_start = 1'b1;
      tick();
      write_start = 1'b0;
      total_cnt++;
      if (write_allframe_done !== 1'b0 || frame_writecnt !== 2'd0)
         $display("FAIL restart: done %b cnt %0d want 0/0", write_allframe_done, frame_writecnt);
      else pass_cnt++;
      push_sequence();
      bursts_done = 0;
      do_burst(BS, 1'b0, 1'b0);
      do_burst(BS, 1'b1, 1'b0);
   endtask

   task automatic test_rst_mid();
      int waited = 0;
      while (bus.wr_burst_req !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      total_cnt++;
      if (waited >= 50) $display("FAIL rst_mid_req: no request within 50 cycles");
      else pass_cnt++;
      bus.wr_burst_data_req = 1'b1;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      total_cnt++;
      if (bus.wr_burst_req !== 1'b0 || bus.wr_burst_len !== BB'(BS) || bus.wr_burst_addr !== '0 ||
          frame_writecnt !== 2'd0 || write_allframe_done !== 1'b0 || bus.fifo_rd_en !== 1'b0)
         $display("FAIL rst_mid: req %b len %0d addr %0d cnt %0d done %b rd_en %b want 0/%0d/0/0/0/0",
                  bus.wr_burst_req, bus.wr_burst_len, bus.wr_burst_addr, frame_writecnt,
                  write_allframe_done, bus.fifo_rd_en, BS);
      else pass_cnt++;
      rst = 1'b0;
      bus.wr_burst_data_req = 1'b0;
      tick();
   endtask

`ifdef FRAME_WR_BEAT_CHECK_EN
   task automatic test_beat_err();
      write_start = 1'b1;
      tick();
      write_start = 1'b0;
      push_sequence();
      bursts_done = 0;
      do_burst(BS - 1, 1'b0, 1'b0);
      total_cnt++;
      if (beat_err !== 1'b1)
         $display("FAIL beat_err_short: got %b want 1 after 7-beat burst", beat_err);
      else pass_cnt++;
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      write_start = 1'b0;
      bus.fifo_rd_usedw = 12'd0;
      bus.fifo_q = '0;
      bus.wr_burst_data_req = 1'b0;
      bus.wr_burst_finish = 1'b0;
      bursts_done = 0;
      test_reset();
      test_threshold();
      test_frames();
      test_done_hold();
      test_restart();
      test_rst_mid();
`ifdef FRAME_WR_BEAT_CHECK_EN
      test_beat_err();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/frame_write_sdram_lot.md
Name: frame_write_sdram_lot

Overview:
Burst-write master that fills the three SDRAM frame buffers from an incoming pixel FIFO (show-ahead) before the frame reader drains them to UART.
Per start command it writes NUM_FRAMES consecutive frames, each FRAME_BURSTS bursts of BURST_SIZE words, at base addresses 0, FRAME_STRIDE and 2*FRAME_STRIDE.
It then raises write_allframe_done, the level the frame reader gates on. It sits between the capture FIFO and the SDRAM controller write port.

Parameters:
MEM_DATA_BITS, 32, controller data width
ADDR_BITS, 23, controller word-address width
BURST_BITS, 10, burst-length field width
BURST_SIZE, 128, words per burst
FRAME_BURSTS, 2560, bursts per frame (12-bit counter)
FRAME_STRIDE, 2073600, word offset between frame buffers
NUM_FRAMES, 3, frames per start command (max 3)

Ports:
mem_clk  in  1  controller user clock; sole clock
rst  in  1  synchronous, active-high reset
write_start  in  1  one-cycle pulse: begin writing all frames
fifo_rd_usedw  in  12  words available in pixel FIFO
fifo_q  in  MEM_DATA_BITS  show-ahead FIFO head word
fifo_rd_en  out  1  FIFO pop
wr_burst_req  out  1  burst write request to controller
wr_burst_len  out  BURST_BITS  burst length in words
wr_burst_addr  out  ADDR_BITS  burst base word address
wr_burst_data_req  in  1  controller consumes one word this cycle
wr_burst_data  out  MEM_DATA_BITS  write data
wr_burst_finish  in  1  controller burst complete pulse
frame_writecnt  out  2  frames fully written since start (0..3)
write_allframe_done  out  1  all frames written; level, held

Behaviour:
- Clock and reset: one clock, mem_clk; rst is synchronous, active-high. Reset values: wr_burst_req=0, wr_burst_len=BURST_SIZE, wr_burst_addr=0, frame_writecnt=0, write_allframe_done=0, state=IDLE, burst_cnt=0, offset=0.
- Data path: fifo_rd_en = wr_burst_data_req & (state==WR_BURST), combinational. wr_burst_data = fifo_q, combinational. Zero latency.
- Address: wr_burst_addr = frame_base + offset. frame_base is 0, FRAME_STRIDE or 2*FRAME_STRIDE by frame index. offset advances BURST_SIZE per burst. All sums are ADDR_BITS wide; no wrap is possible with the defaults.
- States:
  - IDLE: on write_start go to WAIT_DATA; clear frame_writecnt, burst_cnt, offset and write_allframe_done.
  - WAIT_DATA: when fifo_rd_usedw >= BURST_SIZE, load wr_burst_addr, set wr_burst_req=1, wr_burst_len=BURST_SIZE, go to WR_BURST.
  - WR_BURST: on the first wr_burst_data_req, clear wr_burst_req. On wr_burst_finish, offset += BURST_SIZE and burst_cnt++.
    - If burst_cnt was FRAME_BURSTS-1: burst_cnt=0, offset=0, frame_writecnt++.
    - If that frame was frame NUM_FRAMES-1: go to DONE and set write_allframe_done=1.
    - Otherwise go to WAIT_DATA.
  - DONE: hold outputs. write_start returns to WAIT_DATA with counters cleared and write_allframe_done dropped the next cycle.
- Simultaneous wr_burst_data_req and wr_burst_finish in the same cycle: the pop still occurs, then the finish is processed.
- write_start during WAIT_DATA or WR_BURST is ignored.
- FIFO underflow mid-burst is not guarded; the producer must keep ≥BURST_SIZE words before each request.
- rst mid-burst: immediate return to reset values. The controller shares rst, so the burst is abandoned.
- Latency: wr_burst_req rises 1 cycle after usedw reaches threshold in WAIT_DATA.

Optional Feature:
FRAME_WR_BEAT_CHECK_EN
- Defined: counts fifo_rd_en pulses per burst. On wr_burst_finish, a count ≠ BURST_SIZE sets a sticky output beat_err (1 bit, reset 0, cleared by write_start).
- Undefined: no counter and no beat_err port.

Decomposition:
- Shared package frame_sdram_pkg:
  - state encoding: IDLE=0, WAIT_DATA=1, WR_BURST=2, DONE=3
  - FRAME_STRIDE
  - frame base constant array
  - BURST_SIZE default
  - Shared with the frame reader.
- Sub-module frame_wr_addr_gen holds burst_cnt, offset and frame index. It emits the address, frame_last and all_last.

Test Plan:
- Sim params FRAME_BURSTS=4, BURST_SIZE=8. rst, then write_start with usedw=16 → wr_burst_addr sequence 0,8,16,24, then FRAME_STRIDE+0.
- Controller asserts data_req for 8 cycles → exactly 8 fifo_rd_en pulses, wr_burst_data equals fifo_q each beat, wr_burst_req drops after the first data_req.
- usedw=7 held → stays in WAIT_DATA with wr_burst_req=0. usedw=8 → wr_burst_req=1 next cycle.
- Run 12 bursts → frame_writecnt goes 1, 2, 3. write_allframe_done=1 after the 12th finish and stays high for 100 cycles.
- write_start in WR_BURST → ignored. write_start in DONE → write_allframe_done=0 and next address is 0.
- rst asserted mid-burst → all outputs at reset values the following cycle. With FRAME_WR_BEAT_CHECK_EN, finish after 7 beats → beat_err=1.
